// File: rtl/typed_skid_buffer_if.sv
// Valid/ready channel bundle for typed_skid_buffer: upstream (fwd_*) and
// downstream (rev_*) sides of one pipeline stage.
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are sampled high (push = fwd_valid & fwd_ready, pop = rev_valid &
// rev_ready). A source holds valid and data stable until the transfer.
// Ready may be low with or without valid, and data is ignored while valid = 0.
interface typed_skid_buffer_if #(
  parameter type TYPE_T = logic [255:0]
);
  TYPE_T fwd_data;
  logic  fwd_valid;
  logic  fwd_ready;
  TYPE_T rev_data;
  logic  rev_valid;
  logic  rev_ready;

  // Environment side: drives upstream payload, accepts downstream payload.
  modport master (
    output fwd_data, fwd_valid, rev_ready,
    input  fwd_ready, rev_data, rev_valid
  );

  // Block side: accepts upstream payload, drives downstream payload.
  modport slave (
    input  fwd_data, fwd_valid, rev_ready,
    output fwd_ready, rev_data, rev_valid
  );
endinterface

// File: rtl/typed_skid_buffer.sv
// Registered valid/ready stage. Mode 0 is a two-entry skid buffer
// (1 transfer/cycle); Mode 1 is a single-entry slice (1 transfer per 2 cycles).
// fwd_ready, rev_valid and rev_data all come straight from flops, so no
// combinational path crosses the block in either direction.
module typed_skid_buffer #(
  parameter type TYPE_T = logic [255:0],
  parameter int  Mode   = 0
) (
  input  logic                clk,
  input  logic                rst,
  typed_skid_buffer_if.slave  bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  if (Mode == 0 || Mode == 1) begin : g_mode_ok
  end else begin : g_mode_bad
    $error("typed_skid_buffer: Mode must be 0 or 1");
  end

  state_t r_state;
  state_t w_state_next;
  logic   r_fwd_ready;
  logic   r_rev_valid;
  TYPE_T  r_main;   // output register, always holds the oldest entry
  TYPE_T  r_skid;   // overflow register, second entry while FULL

  logic   w_push;
  logic   w_pop;
  logic   w_load_main_fwd;
  logic   w_load_main_skid;
  logic   w_load_skid;
  logic   w_fwd_ready_next;
  logic   w_rev_valid_next;

  assign w_push = bus.fwd_valid & r_fwd_ready;
  assign w_pop  = r_rev_valid & bus.rev_ready;

  // Next-state, register-load selects and next output flags.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_fwd  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (Mode == 1) begin
      case (r_state)
        EMPTY: if (w_push) begin
          w_state_next    = ONE;
          w_load_main_fwd = 1'b1;
        end
        ONE:   if (w_pop) w_state_next = EMPTY;
        default: w_state_next = EMPTY;
      endcase
    end else begin
      case (r_state)
        EMPTY: if (w_push) begin
          w_state_next    = ONE;
          w_load_main_fwd = 1'b1;
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_load_main_fwd = 1'b1;
          end else if (w_push) begin
            w_state_next = FULL;
            w_load_skid  = 1'b1;
          end else if (w_pop) begin
            w_state_next = EMPTY;
          end
        end
        FULL: if (w_pop) begin
          w_state_next     = ONE;
          w_load_main_skid = 1'b1;
        end
        default: w_state_next = EMPTY;
      endcase
    end
    w_rev_valid_next = (w_state_next != EMPTY);
    w_fwd_ready_next = (Mode == 1) ? (w_state_next == EMPTY)
                                   : (w_state_next != FULL);
  end

  // State and handshake flags; reset empties the stage and blocks upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_rev_valid <= 1'b0;
      r_fwd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rev_valid <= w_rev_valid_next;
      r_fwd_ready <= w_fwd_ready_next;
    end
  end

  // Payload registers carry no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_load_main_fwd) begin
      r_main <= bus.fwd_data;
    end else if (w_load_main_skid) begin
      r_main <= r_skid;
    end
    if (w_load_skid) begin
      r_skid <= bus.fwd_data;
    end
  end

  assign bus.fwd_ready = r_fwd_ready;
  assign bus.rev_valid = r_rev_valid;
  assign bus.rev_data  = r_main;
  assign o_dbg_state   = r_state;

  a_stall_stable : assert property (@(posedge clk) disable iff (rst)
    (r_rev_valid && !bus.rev_ready) |=> (r_rev_valid && $stable(r_main)));

  a_reset_quiet : assert property (@(posedge clk)
    rst |=> (!r_fwd_ready && !r_rev_valid));

endmodule

// File: tb/tb_typed_skid_buffer.sv
// Bench for typed_skid_buffer: one Mode 0 and one Mode 1 instance side by
// side, a scoreboard queue per instance, directed steps then a random run.
module tb_typed_skid_buffer;

  logic       clk;
  logic       rst;
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  typed_skid_buffer_if #(.TYPE_T(logic [7:0])) if0 ();
  typed_skid_buffer_if #(.TYPE_T(logic [7:0])) if1 ();

  typed_skid_buffer #(.TYPE_T(logic [7:0]), .Mode(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0), .o_dbg_state(dbg0)
  );
  typed_skid_buffer #(.TYPE_T(logic [7:0]), .Mode(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1), .o_dbg_state(dbg1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pushes0, pops0, pushes1, pops1;
  int first_push0, first_pop0, last_pop0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pushes0 = 0; pops0 = 0; pushes1 = 0; pops1 = 0;
    first_push0 = -1; first_pop0 = -1; last_pop0 = -1;
  endtask

  // One clock cycle: score handshakes seen at this edge, then check stall hold.
  task automatic tick();
    logic       push0, pop0, push1, pop1, stall0, stall1;
    logic [7:0] hold0, hold1, e;
    push0  = !rst && if0.fwd_valid && if0.fwd_ready;
    pop0   = !rst && if0.rev_valid && if0.rev_ready;
    push1  = !rst && if1.fwd_valid && if1.fwd_ready;
    pop1   = !rst && if1.rev_valid && if1.rev_ready;
    stall0 = !rst && if0.rev_valid && !if0.rev_ready;
    stall1 = !rst && if1.rev_valid && !if1.rev_ready;
    hold0  = if0.rev_data;
    hold1  = if1.rev_data;
    if (pop0) begin
      chk("pop0_expected", exp_q0.size() != 0, 1);
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        chk("pop0_data", if0.rev_data, e);
      end
      pops0++;
      if (first_pop0 < 0) first_pop0 = cyc;
      last_pop0 = cyc;
    end
    if (push0) begin
      exp_q0.push_back(if0.fwd_data);
      pushes0++;
      if (first_push0 < 0) first_push0 = cyc;
    end
    if (pop1) begin
      chk("pop1_expected", exp_q1.size() != 0, 1);
      if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        chk("pop1_data", if1.rev_data, e);
      end
      pops1++;
    end
    if (push1) begin
      exp_q1.push_back(if1.fwd_data);
      pushes1++;
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end
    @(negedge clk);
    if (stall0) begin
      chk("stall0_valid", if0.rev_valid, 1);
      chk("stall0_data", if0.rev_data, hold0);
    end
    if (stall1) begin
      chk("stall1_valid", if1.rev_valid, 1);
      chk("stall1_data", if1.rev_data, hold1);
    end
  endtask

  initial begin
    logic prev_ready;
    logic pushed;
    int   k;

    // ---- Reset held 3 cycles with fwd_valid high ----
    rst = 1'b1;
    if0.fwd_valid = 1'b1; if0.fwd_data = 8'hEE; if0.rev_ready = 1'b0;
    if1.fwd_valid = 1'b1; if1.fwd_data = 8'hEE; if1.rev_ready = 1'b0;
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_fwd_ready0", if0.fwd_ready, 0);
      chk("rst_rev_valid0", if0.rev_valid, 0);
      chk("rst_fwd_ready1", if1.fwd_ready, 0);
      chk("rst_rev_valid1", if1.rev_valid, 0);
    end
    rst = 1'b0;
    tick();
    chk("rel_fwd_ready0", if0.fwd_ready, 1);
    chk("rel_fwd_ready1", if1.fwd_ready, 1);
    chk("rel_rev_valid0", if0.rev_valid, 0);
    chk("rel_rev_valid1", if1.rev_valid, 0);
    if0.fwd_valid = 1'b0;
    if1.fwd_valid = 1'b0;

    // ---- Mode 0 streaming 0x01..0x10 ----
    clear_stats();
    if0.rev_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if0.fwd_valid = 1'b1;
      if0.fwd_data  = 8'(i);
      tick();
    end
    if0.fwd_valid = 1'b0;
    for (int t = 0; t < 8 && exp_q0.size() != 0; t++) tick();
    chk("stream_pushes", pushes0, 16);
    chk("stream_pops", pops0, 16);
    chk("stream_latency", first_pop0 - first_push0, 1);
    chk("stream_back_to_back", last_pop0 - first_pop0, 15);
    chk("stream_drained", exp_q0.size(), 0);

    // ---- Mode 0 stall and skid ----
    clear_stats();
    if0.rev_ready = 1'b0;
    if0.fwd_valid = 1'b1; if0.fwd_data = 8'hA1;
    tick();
    chk("skid_ready_after_1", if0.fwd_ready, 1);
    if0.fwd_data = 8'hA2;
    tick();
    if0.fwd_valid = 1'b0;
    chk("skid_ready_after_2", if0.fwd_ready, 0);
    chk("skid_state_full", dbg0, 2);
    chk("skid_head", if0.rev_data, 8'hA1);
    tick();
    tick();
    chk("skid_head_held", if0.rev_data, 8'hA1);
    if0.rev_ready = 1'b1;
    tick();
    chk("skid_ready_after_pop", if0.fwd_ready, 1);
    chk("skid_second_valid", if0.rev_valid, 1);
    chk("skid_second_data", if0.rev_data, 8'hA2);
    tick();
    chk("skid_empty", if0.rev_valid, 0);
    chk("skid_pops", pops0, 2);
    chk("skid_consecutive", last_pop0 - first_pop0, 1);

    // ---- Mode 1 throughput ----
    clear_stats();
    if1.rev_ready = 1'b1;
    k = 0;
    prev_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if1.fwd_valid = (k < 8);
      if1.fwd_data  = 8'(8'h30 + k);
      if (c == 0) chk("m1_ready_first", if1.fwd_ready, 1);
      else        chk("m1_ready_alt", if1.fwd_ready, !prev_ready);
      prev_ready = if1.fwd_ready;
      pushed = if1.fwd_valid && if1.fwd_ready;
      tick();
      if (pushed) k++;
    end
    if1.fwd_valid = 1'b0;
    chk("m1_pushes", pushes1, 8);
    chk("m1_pops", pops1, 8);
    chk("m1_drained", exp_q1.size(), 0);
    chk("m1_idle", if1.rev_valid, 0);

    // ---- Mode 0 reset while FULL ----
    if0.rev_ready = 1'b0;
    if0.fwd_valid = 1'b1; if0.fwd_data = 8'h55;
    tick();
    if0.fwd_data = 8'h66;
    tick();
    if0.fwd_valid = 1'b0;
    chk("mr_state_full", dbg0, 2);
    chk("mr_head", if0.rev_data, 8'h55);
    rst = 1'b1;
    tick();
    chk("mr_rev_valid", if0.rev_valid, 0);
    chk("mr_fwd_ready", if0.fwd_ready, 0);
    rst = 1'b0;
    tick();
    chk("mr_ready_back", if0.fwd_ready, 1);
    chk("mr_still_empty", if0.rev_valid, 0);
    clear_stats();
    if0.fwd_valid = 1'b1; if0.fwd_data = 8'h77; if0.rev_ready = 1'b1;
    tick();
    if0.fwd_valid = 1'b0;
    chk("mr_new_valid", if0.rev_valid, 1);
    chk("mr_new_data", if0.rev_data, 8'h77);
    tick();
    chk("mr_pops", pops0, 1);
    chk("mr_drained", exp_q0.size(), 0);

    // ---- Random traffic ----
    clear_stats();
    for (int i = 0; i < 10000; i++) begin
      if0.fwd_valid = 1'($urandom_range(0, 1));
      if0.rev_ready = 1'($urandom_range(0, 1));
      if0.fwd_data  = 8'($urandom_range(0, 255));
      if1.fwd_valid = 1'($urandom_range(0, 1));
      if1.rev_ready = 1'($urandom_range(0, 1));
      if1.fwd_data  = 8'($urandom_range(0, 255));
      tick();
    end
    if0.fwd_valid = 1'b0; if0.rev_ready = 1'b1;
    if1.fwd_valid = 1'b0; if1.rev_ready = 1'b1;
    for (int t = 0; t < 8 && (exp_q0.size() != 0 || exp_q1.size() != 0); t++) tick();
    chk("rand0_activity", pushes0 > 1000, 1);
    chk("rand1_activity", pushes1 > 1000, 1);
    chk("rand0_count", pops0, pushes0);
    chk("rand1_count", pops1, pushes1);
    chk("rand0_drained", exp_q0.size(), 0);
    chk("rand1_drained", exp_q1.size(), 0);
    chk("rand0_idle", if0.rev_valid, 0);
    chk("rand1_idle", if1.rev_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
